// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Each digit slot starts with DEAD dark cycles; new values are taken only at frame boundaries or while off.
module display_scan_ctrl #(
   parameter int DIV  = 50000,
   parameter int DEAD = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  dp_mask,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic        frame_tick,
   output logic [11:0] segs
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
   localparam logic [CW-1:0] ON_LAST   = CW'(DIV - DEAD - 1);

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_DEAD = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;

   logic [1:0]    state;
   logic [1:0]    idx;
   logic [CW-1:0] cnt;
   logic [15:0]   sh_digits;
   logic [3:0]    sh_blank;
   logic [3:0]    sh_dp;
   logic          boundary;
   logic          load;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // The last ON cycle of digit 3 closes the frame, whether or not en is still high.
   assign boundary = (state == S_ON) && (idx == 2'd3) && (cnt == ON_LAST);
   // While off, an ack in flight suppresses a reload so a held request is not acked twice in a row.
   assign load     = upd_req && (boundary || ((state == S_OFF) && !upd_ack));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_OFF;
         idx        <= 2'd0;
         cnt        <= '0;
         sh_digits  <= '0;
         sh_blank   <= '0;
         sh_dp      <= '0;
         upd_ack    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         upd_ack    <= load;
         frame_tick <= boundary && en;
         if (load) begin
            sh_digits <= digits;
            sh_blank  <= blank_mask;
            sh_dp     <= dp_mask;
         end
         if (!en) begin
            state <= S_OFF;
            idx   <= 2'd0;
            cnt   <= '0;
         end else begin
            case (state)
               S_OFF: begin
                  state <= S_DEAD;
                  idx   <= 2'd0;
                  cnt   <= '0;
               end
               S_DEAD: begin
                  if (cnt == DEAD_LAST) begin
                     state <= S_ON;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_ON: begin
                  if (cnt == ON_LAST) begin
                     state <= S_DEAD;
                     cnt   <= '0;
                     idx   <= idx + 2'd1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= S_OFF;
                  idx   <= 2'd0;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   // Output decode looks only at registered state and shadows.
   always_comb begin
      segs = 12'hFFF;
      nib  = sh_digits[idx*4 +: 4];
      if ((state == S_ON) && !sh_blank[idx]) begin
         segs[6:0] = ~hex7(nib);
         segs[8]   = ~sh_dp[idx];
         case (idx)
            2'd0:    segs[7]  = 1'b0;
            2'd1:    segs[9]  = 1'b0;
            2'd2:    segs[10] = 1'b0;
            default: segs[11] = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIV=10, DEAD=2: directed stimulus pushes
// hand-computed per-cycle expectations; a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

   typedef struct {
      logic [11:0] segs;
      logic        ack;
      logic        tick;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] digits;
   logic [3:0]  blank_mask;
   logic [3:0]  dp_mask;
   logic        upd_req;
   logic        upd_ack;
   logic        frame_tick;
   logic [11:0] segs;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   display_scan_ctrl #(.DIV(10), .DEAD(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .digits     (digits),
      .blank_mask (blank_mask),
      .dp_mask    (dp_mask),
      .upd_req    (upd_req),
      .upd_ack    (upd_ack),
      .frame_tick (frame_tick),
      .segs       (segs)
   );

   always #5 clk = ~clk;

   // Monitor: the display presents a new output every cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (segs !== e.segs || upd_ack !== e.ack || frame_tick !== e.tick) begin
            errors++;
            $display("FAIL %s t=%0t: got segs=%h ack=%b tick=%b, want segs=%h ack=%b tick=%b",
                     e.tag, $time, segs, upd_ack, frame_tick, e.segs, e.ack, e.tick);
         end
      end
   end

   // Advance one clock edge and queue what the outputs must show after it.
   task automatic step(input logic [11:0] s, input logic a, input logic t, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      e.segs = s;
      e.ack  = a;
      e.tick = t;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   // One 40-cycle frame; optionally raise an update request at cycle req_at.
   task automatic run_frame(input logic [11:0] s0, input logic [11:0] s1,
                            input logic [11:0] s2, input logic [11:0] s3,
                            input logic tk, input logic ak, input int req_at,
                            input logic [15:0] nd, input logic [3:0] nb,
                            input logic [3:0] ndp, input string tag);
      logic [11:0] sarr[4];
      sarr[0] = s0; sarr[1] = s1; sarr[2] = s2; sarr[3] = s3;
      for (int i = 0; i < 40; i++) begin
         if (i == req_at) begin
            digits     = nd;
            blank_mask = nb;
            dp_mask    = ndp;
            upd_req    = 1'b1;
         end
         step(((i % 10) < 2) ? 12'hFFF : sarr[i / 10],
              (i == 0) ? ak : 1'b0, (i == 0) ? tk : 1'b0, tag);
         if (i == 0 && ak) upd_req = 1'b0;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      upd_req    = 1'b1;
      digits     = 16'hABCD;
      blank_mask = 4'h0;
      dp_mask    = 4'hF;

      step(12'hFFF, 1'b0, 1'b0, "reset0");
      step(12'hFFF, 1'b0, 1'b0, "reset1");

      // Load while off: ack shows one cycle after the load edge.
      rst_n   = 1'b1;
      en      = 1'b0;
      digits  = 16'h4321;
      dp_mask = 4'h0;
      step(12'hFFF, 1'b1, 1'b0, "off_ack");
      upd_req = 1'b0;
      step(12'hFFF, 1'b0, 1'b0, "off_idle");

      en = 1'b1;
      run_frame(12'hF79, 12'hDA4, 12'hBB0, 12'h799, 1'b0, 1'b0, -1, 16'h0, 4'h0, 4'h0, "frame1");
      run_frame(12'hF79, 12'hDA4, 12'hBB0, 12'h799, 1'b1, 1'b0, -1, 16'h0, 4'h0, 4'h0, "frame2");
      // Mid-frame request must not show before the boundary.
      run_frame(12'hF79, 12'hDA4, 12'hBB0, 12'h799, 1'b1, 1'b0, 15, 16'h00F0, 4'h0, 4'h0, "frame3_old");
      run_frame(12'hF40, 12'hD8E, 12'hBC0, 12'h7C0, 1'b1, 1'b1, 5, 16'h00F0, 4'b1000, 4'b0001, "frame4_new");
      run_frame(12'hE40, 12'hD8E, 12'hBC0, 12'hFFF, 1'b1, 1'b1, -1, 16'h0, 4'h0, 4'h0, "frame5_mask");

      // Drop en in the middle of the digit 0 ON window.
      step(12'hFFF, 1'b0, 1'b1, "f6_tick");
      step(12'hFFF, 1'b0, 1'b0, "f6_dead");
      for (int i = 0; i < 3; i++) step(12'hE40, 1'b0, 1'b0, "f6_on");
      en = 1'b0;
      step(12'hFFF, 1'b0, 1'b0, "en_drop");
      step(12'hFFF, 1'b0, 1'b0, "en_off");

      // Pending update aborted by reset: never acked, shadows cleared.
      en = 1'b1;
      step(12'hFFF, 1'b0, 1'b0, "restart_dead0");
      step(12'hFFF, 1'b0, 1'b0, "restart_dead1");
      digits  = 16'h1234;
      upd_req = 1'b1;
      for (int i = 0; i < 3; i++) step(12'hE40, 1'b0, 1'b0, "pend_on");
      rst_n = 1'b0;
      step(12'hFFF, 1'b0, 1'b0, "rst_pend0");
      step(12'hFFF, 1'b0, 1'b0, "rst_pend1");
      rst_n   = 1'b1;
      upd_req = 1'b0;
      en      = 1'b0;
      step(12'hFFF, 1'b0, 1'b0, "post_rst0");
      step(12'hFFF, 1'b0, 1'b0, "post_rst1");
      en = 1'b1;
      step(12'hFFF, 1'b0, 1'b0, "zero_dead0");
      step(12'hFFF, 1'b0, 1'b0, "zero_dead1");
      for (int i = 0; i < 3; i++) step(12'hF40, 1'b0, 1'b0, "zero_shadow");

      // Let the monitor drain, with a bound.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
